sort_ctrl: RTL and testbench
============================

// Module: sort_ctrl
// PURPOSE
//   Sequencer around one shared WIDTH-bit magnitude comparator (comp).
//   Accepts a block of DEPTH unsigned values over a valid/ready input port.
//   Sorts the block ascending by bubble sort, one comparison per cycle.
//   Streams the sorted block out over a valid/ready output port, then reloads.
// PARAMETERS
//   WIDTH  4  data width in bits; matches comp operand width
//   DEPTH  8  values per block; power of two, >= 2
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      in_data valid
//   in_ready  out  1      block accepts in_data (LOAD state only)
//   in_data   in   WIDTH  unsigned value to load
//   out_valid out  1      out_data valid (DRAIN state only)
//   out_ready in   1      consumer accepts out_data
//   out_data  out  WIDTH  sorted value, ascending order
//   out_last  out  1      high with the DEPTH-th (largest) output value
//   busy      out  1      high in SORT and DRAIN
// BEHAVIOUR
//   Reset: state=LOAD; wr_ptr, rd_ptr, idx, pass = 0; swap_flag = 0.
//     Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
//     Storage array is not reset. Reset mid-SORT or mid-DRAIN discards the block.
//   Outputs decode from registered state and pointers; no input-to-output comb path.
//   Transfers: a transfer occurs on a clk edge with valid & ready both high.
//   LOAD:
//     Each input transfer writes mem[wr_ptr] and increments wr_ptr.
//     On the DEPTH-th transfer, next state = SORT, wr_ptr wraps to 0, in_ready drops.
//   SORT:
//     Every cycle, comp compares a = mem[idx] and b = mem[idx+1].
//     If a_gt_b: swap the two entries at the edge and set swap_flag.
//     If a_eq_b or a_ls_b: no swap; equal keys keep their order.
//     While idx < DEPTH-2: idx increments.
//     At idx == DEPTH-2 (end of pass):
//       Go to DRAIN if no swap occurred this pass (this compare included),
//         or if pass == DEPTH-2.
//       Otherwise idx = 0, pass increments, swap_flag clears.
//     Cost: DEPTH-1 compares per pass; at most DEPTH-1 passes.
//     SORT duration: best DEPTH-1 cycles, worst (DEPTH-1)^2 cycles.
//   DRAIN:
//     out_valid = 1, out_data = mem[rd_ptr], out_last = (rd_ptr == DEPTH-1).
//     out_data is stable while out_valid & !out_ready.
//     On each output transfer rd_ptr increments.
//     After the out_last transfer: state = LOAD, all counters clear,
//       in_ready = 1 on the following cycle.
//   in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
//   Counter widths: wr_ptr, rd_ptr, idx, pass are $clog2(DEPTH) bits; wrap is
//     never reached except as stated.
// STRUCTURE
//   sort_defs.vh (shared include):
//     state encodings ST_LOAD=2'd0, ST_SORT=2'd1, ST_DRAIN=2'd2.
//   Sub-module: one instance of existing comp (a, b, a_gt_b, a_ls_b, a_eq_b).
//     Its outputs are the only swap decision source.
//   Storage: DEPTH x WIDTH register array, so one swap writes two entries
//     in one cycle.
// TESTING (WIDTH=4, DEPTH=8)
//   1 Load 3,1,4,1,5,9,2,6 -> out 1,1,2,3,4,5,6,9; out_last only with 9.
//   2 Load 0..7 (already sorted) -> SORT exactly 7 cycles; out 0..7.
//   3 Load F,E,D,C,B,A,9,8 -> SORT exactly 49 cycles; out 8..F.
//   4 Load A x8 -> SORT 7 cycles with no swaps; out A x8.
//   5 out_ready toggled 1010... -> out_data held while stalled; no value lost
//     or duplicated; in_ready stays 0 until the out_last transfer.
//   6 rst_n low 3 cycles into SORT -> busy=0, in_ready=1, out_valid=0 at once;
//     then load 7,6,5,4,3,2,1,0 -> out 0..7.

Source files
------------

// File: rtl/sort_ctrl_pkg.sv
// Shared types and helpers for the sort_ctrl block: FSM state encoding and
// pointer-width calculation.
package sort_ctrl_pkg;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StSort  = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Width of a pointer that indexes DEPTH entries; never narrower than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/comp.sv
// Unsigned WIDTH-bit magnitude comparator, shared by the sort sequencer.
module comp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_ls_b,
  output logic             a_eq_b
);

  assign a_gt_b = (a > b);
  assign a_ls_b = (a < b);
  assign a_eq_b = (a == b);

endmodule

// File: rtl/sort_ctrl.sv
// Block sorter: loads DEPTH values, bubble-sorts them ascending with one shared
// comparator (one compare per cycle), then streams them out in order.
module sort_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);
  // Last compare index in a pass, and also the final permitted pass number.
  localparam logic [PW-1:0] CmpEnd  = PW'(DEPTH - 2);

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            swap_flag_q, swap_flag_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    idx_nxt;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             a_gt_b, a_ls_b, a_eq_b;
  logic             do_swap;
  logic             mem_we, swap_en;
  logic             in_xfer, out_xfer;

  assign idx_nxt = idx_q + PW'(1);
  assign cmp_a   = mem[idx_q];
  assign cmp_b   = mem[idx_nxt];

  comp #(
    .WIDTH (WIDTH)
  ) u_comp (
    .a      (cmp_a),
    .b      (cmp_b),
    .a_gt_b (a_gt_b),
    .a_ls_b (a_ls_b),
    .a_eq_b (a_eq_b)
  );

  // Ties and ascending pairs both hold their place, keeping the sort stable.
  assign do_swap = a_gt_b & ~(a_ls_b | a_eq_b);

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q != StLoad);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign out_last  = out_valid && (rd_ptr_q == LastIdx);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    swap_flag_d = swap_flag_q;
    mem_we      = 1'b0;
    swap_en     = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_xfer) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q == LastIdx) begin
            wr_ptr_d = '0;
            state_d  = StSort;
          end
        end
      end

      StSort: begin
        swap_en = do_swap;
        if (idx_q == CmpEnd) begin
          idx_d       = '0;
          swap_flag_d = 1'b0;
          if (!(swap_flag_q | do_swap) || (pass_q == CmpEnd)) begin
            pass_d  = '0;
            state_d = StDrain;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end else begin
          idx_d       = idx_nxt;
          swap_flag_d = swap_flag_q | do_swap;
        end
      end

      StDrain: begin
        if (out_xfer) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == LastIdx) begin
            rd_ptr_d = '0;
            state_d  = StLoad;
          end
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      swap_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      swap_flag_q <= swap_flag_d;
    end
  end

  // Storage is deliberately unreset; a swap rewrites both compared entries.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end else if (swap_en) begin
      mem[idx_q]   <= cmp_b;
      mem[idx_nxt] <= cmp_a;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl: directed and random blocks, expected order and
// sort duration derived from a behavioural model, checked by a separate monitor.
module tb_sort_ctrl;

  localparam int W = 4;
  localparam int D = 8;

  typedef logic [W-1:0] blk_t [D];
  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   rdy_mode = 0;

  sort_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic finish_now(input string why);
    vectors++;
    errors++;
    $display("FAIL %s: timed out", why);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "bench stopped");
  endtask

  // Model: sorted order by counting over the value range; duration by passes
  // of bubble sort, stopping after a clean pass or after DEPTH-1 passes.
  task automatic model(input blk_t v);
    blk_t a;
    int   n;
    int   cycles;
    bit   sw;
    logic [W-1:0] t;
    exp_t e;
    n = 0;
    for (int val = 0; val < (1 << W); val++) begin
      for (int i = 0; i < D; i++) begin
        if (int'(v[i]) == val) begin
          n++;
          e.data = W'(val);
          e.last = (n == D);
          exp_q.push_back(e);
        end
      end
    end
    a = v;
    cycles = 0;
    for (int p = 0; p < D - 1; p++) begin
      sw = 1'b0;
      for (int i = 0; i < D - 1; i++) begin
        if (a[i] > a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          sw = 1'b1;
        end
      end
      cycles += D - 1;
      if (!sw) break;
    end
    cyc_q.push_back(cycles);
  endtask

  task automatic load_block(input blk_t v, input bit push, input bit gaps);
    int t;
    if (push) model(v);
    for (int i = 0; i < D; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 2000) finish_now("load_wait");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, (1 << W) - 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 || busy) begin
      @(posedge clk); #1;
      t++;
      if (t > 5000) finish_now("drain_wait");
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer and measures SORT time.
  initial begin
    int           sort_cnt = 0;
    bit           seen_drain = 1'b0;
    bit           held_v = 1'b0;
    logic [W-1:0] held_d = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sort_cnt   = 0;
        seen_drain = 1'b0;
        held_v     = 1'b0;
      end else begin
        if (busy && !out_valid) sort_cnt++;
        if (out_valid) begin
          if (!seen_drain) begin
            seen_drain = 1'b1;
            if (cyc_q.size() != 0) check("sort_cycles", sort_cnt, cyc_q.pop_front());
          end
          check("in_ready_during_drain", int'(in_ready), 0);
          if (held_v) check("stall_hold", int'(out_data), int'(held_d));
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL extra_output: got %0d, expected no output", out_data);
            end else begin
              e = exp_q.pop_front();
              check("out_data", int'(out_data), int'(e.data));
              check("out_last", int'(out_last), int'(e.last));
            end
            held_v = 1'b0;
          end else begin
            held_v = 1'b1;
            held_d = out_data;
          end
        end else begin
          held_v = 1'b0;
        end
        if (!busy) begin
          sort_cnt   = 0;
          seen_drain = 1'b0;
        end
      end
    end
  end

  initial begin
    blk_t b;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rdy_mode = 0;
    b = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
    load_block(b, 1'b1, 1'b0);
    wait_idle();
    b = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    load_block(b, 1'b1, 1'b0);
    wait_idle();
    b = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    load_block(b, 1'b1, 1'b0);
    wait_idle();
    b = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    load_block(b, 1'b1, 1'b0);
    wait_idle();

    rdy_mode = 1;
    b = '{4'd12, 4'd3, 4'd7, 4'd0, 4'd15, 4'd3, 4'd9, 4'd1};
    load_block(b, 1'b1, 1'b0);
    wait_idle();

    // Reset three cycles into a long sort; the block is discarded.
    rdy_mode = 0;
    b = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    load_block(b, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsort_rst_busy", int'(busy), 0);
    check("midsort_rst_in_ready", int'(in_ready), 1);
    check("midsort_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    load_block(b, 1'b1, 1'b0);
    wait_idle();

    rdy_mode = 2;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < D; i++) begin
        b[i] = (k % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, (1 << W) - 1));
      end
      load_block(b, 1'b1, 1'b1);
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
